// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel frame controller.
package sobel_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StFlush
    } sobel_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_raster_cnt.sv
// Column/row raster position counter with row-end and frame-end flags.
module sobel_raster_cnt
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P  = 640,
    parameter int unsigned HEIGHT_P = 480
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic beat_i,
    output logic first_o,
    output logic last_col_o,
    output logic terminal_o
);

    localparam int unsigned ColW = cnt_width(WIDTH_P);
    localparam int unsigned RowW = cnt_width(HEIGHT_P);
    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH_P - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT_P - 1);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            last_row;

    assign last_col_o = (col_q == ColLast);
    assign last_row   = (row_q == RowLast);
    assign terminal_o = last_col_o & last_row;
    assign first_o    = (col_q == '0) & (row_q == '0);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (beat_i) begin
            if (last_col_o) begin
                col_d = '0;
                // Frame end returns to origin rather than running past N.
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around a streaming Sobel filter: feeds one frame in, drains it out,
// checks row alignment of the filter output and flushes the filter on abort.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P      = 640,
    parameter int unsigned HEIGHT_P     = 480,
    parameter int unsigned CHANNELS_P   = 3,
    parameter int unsigned FLUSH_IDLE_P = 16
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic                    src_valid_i,
    output logic                    src_ready_o,
    input  logic [CHANNELS_P*8-1:0] src_pixel_i,
    output logic                    pipe_valid_o,
    input  logic                    pipe_ready_i,
    output logic [CHANNELS_P*8-1:0] pipe_pixel_o,
    input  logic                    pipe_valid_i,
    output logic                    pipe_ready_o,
    input  logic [CHANNELS_P*8-1:0] pipe_pixel_i,
    input  logic                    pipe_last_i,
    output logic                    sink_valid_o,
    input  logic                    sink_ready_i,
    output logic [CHANNELS_P*8-1:0] sink_pixel_o,
    output logic                    sink_last_o,
    output logic                    sink_sof_o
);

    localparam int unsigned IdleW = cnt_width(FLUSH_IDLE_P);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(FLUSH_IDLE_P - 1);

    sobel_state_e     state_q;
    logic             busy_q, done_q, err_q;
    logic [IdleW-1:0] idle_cnt_q;

    logic feed, drain, flush, active;
    logic start_go, in_beat, out_beat, out_mismatch;
    logic in_term, out_term, out_first, out_last_col;
    logic in_first, in_last_col;
    logic unused_in_flags;

    assign feed   = (state_q == StFeed);
    assign drain  = (state_q == StDrain);
    assign flush  = (state_q == StFlush);
    assign active = feed | drain;

    assign start_go = (state_q == StIdle) & start_i;

    // Input side: straight wires to the filter, gated by FEED.
    assign pipe_valid_o = src_valid_i & feed;
    assign src_ready_o  = pipe_ready_i & feed;
    assign pipe_pixel_o = src_pixel_i;
    assign in_beat      = pipe_valid_o & pipe_ready_i;

    // Output side: forwarded while the frame is live, swallowed during FLUSH.
    assign sink_valid_o = pipe_valid_i & active;
    assign pipe_ready_o = (sink_ready_i & active) | flush;
    assign sink_pixel_o = pipe_pixel_i;
    assign out_beat     = sink_valid_o & sink_ready_i;

    assign sink_last_o  = out_last_col;
    assign sink_sof_o   = out_first;
    assign out_mismatch = (pipe_last_i != sink_last_o);

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    sobel_raster_cnt #(
        .WIDTH_P  (WIDTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_in_cnt (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .clear_i    (start_go),
        .beat_i     (in_beat),
        .first_o    (in_first),
        .last_col_o (in_last_col),
        .terminal_o (in_term)
    );

    sobel_raster_cnt #(
        .WIDTH_P  (WIDTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_out_cnt (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .clear_i    (start_go),
        .beat_i     (out_beat),
        .first_o    (out_first),
        .last_col_o (out_last_col),
        .terminal_o (out_term)
    );

    // Only the frame-end flag of the input counter matters.
    assign unused_in_flags = in_first ^ in_last_col;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StFeed;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                StFeed, StDrain: begin
                    if (out_beat && out_mismatch) begin
                        err_q <= 1'b1;
                    end
                    if (abort_i) begin
                        state_q    <= StFlush;
                        idle_cnt_q <= '0;
                    end else if (out_beat && out_term && (drain || (in_beat && in_term))) begin
                        // A zero-latency filter can finish both sides in the same cycle.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (feed && in_beat && in_term) begin
                        state_q <= StDrain;
                    end
                end
                StFlush: begin
                    if (pipe_valid_i) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IdleLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_P, default 640, pixels per row.
REQ-002 SHALL have parameter HEIGHT_P, default 480, rows per frame.
REQ-003 SHALL have parameter CHANNELS_P, default 3, 8-bit channels per pixel (pixel width PW = CHANNELS_P*8).
REQ-004 SHALL have parameter FLUSH_IDLE_P, default 16, consecutive idle cycles ending a flush.
REQ-005 SHALL have ports, in order:
- clk_i  in  1  single clock, rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin one frame (sampled in IDLE only).
- abort_i  in  1  abandon current frame.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse, frame complete.
- err_o  out  1  sticky row-alignment error.
- src_valid_i / src_ready_o / src_pixel_i  in/out/in  1/1/PW  upstream pixel stream.
- pipe_valid_o / pipe_ready_i / pipe_pixel_o  out/in/out  1/1/PW  to filter input.
- pipe_valid_i / pipe_ready_o / pipe_pixel_i / pipe_last_i  in/out/in/in  1/1/PW/1  from filter output.
- sink_valid_o / sink_ready_i / sink_pixel_o / sink_last_o / sink_sof_o  out/in/out/out/out  1/1/PW/1/1  downstream stream.

Function
REQ-006 SHALL implement states IDLE, FEED, DRAIN, FLUSH; N = WIDTH_P*HEIGHT_P.
REQ-007 IDLE: start_i=1 -> FEED; clears in/out counters and err_o on that edge.
REQ-008 Input path SHALL be combinational, zero latency: pipe_valid_o = src_valid_i & (state==FEED); src_ready_o = pipe_ready_i & (state==FEED); pipe_pixel_o = src_pixel_i.
REQ-009 Input beat (pipe_valid_o & pipe_ready_i) SHALL advance in_col; in_col wraps at WIDTH_P-1 to 0 and increments in_row.
REQ-010 FEED -> DRAIN on the cycle the N-th input beat is accepted; no further input accepted.
REQ-011 Output path in FEED/DRAIN: sink_valid_o = pipe_valid_i; pipe_ready_o = sink_ready_i; sink_pixel_o = pipe_pixel_i; combinational.
REQ-012 In IDLE: pipe_ready_o=0, sink_valid_o=0, src_ready_o=0, pipe_valid_o=0.
REQ-013 Output beat (sink_valid_o & sink_ready_i) SHALL advance out_col/out_row with same wrap rule; sink_last_o = (out_col==WIDTH_P-1); sink_sof_o = (out_col==0 & out_row==0).
REQ-014 On each output beat where pipe_last_i != sink_last_o, err_o SHALL set and hold until next start.
REQ-015 DRAIN -> IDLE on the N-th output beat; done_o registered, high exactly the following cycle.
REQ-016 abort_i=1 in FEED or DRAIN -> FLUSH next cycle; abort wins over simultaneous N-th input or output beat; no done_o.
REQ-017 FLUSH: src_ready_o=0, pipe_valid_o=0, sink_valid_o=0, pipe_ready_o=1 (discard); idle counter increments when pipe_valid_i=0, clears when 1; reaching FLUSH_IDLE_P -> IDLE.
REQ-018 start_i outside IDLE and abort_i in IDLE/FLUSH SHALL be ignored.
REQ-019 Counters SHALL be $clog2 wide of WIDTH_P/HEIGHT_P (minimum 1 bit); no overflow past N.

Reset
REQ-020 resetn_i=0 SHALL asynchronously force state IDLE, all counters 0, done_o=0, err_o=0, busy_o=0; all stream valid/ready outputs 0.
REQ-021 Reset mid-frame SHALL discard progress; first cycle after release is IDLE.

Structure
REQ-022 Package sobel_pkg SHALL hold the state enum and a count-width function.
REQ-023 Sub-module sobel_raster_cnt (col/row counter, wrap, terminal flag) SHALL be instantiated twice (input, output).

Verification
REQ-024 Bench SHALL use WIDTH_P=4, HEIGHT_P=3, FLUSH_IDLE_P=4, filter modelled as 2-deep FIFO asserting last every 4th beat.
REQ-025 start pulse, 12 pixels 0x000001..0x00000C, sink_ready=1 -> 12 outputs, sink_last on beats 4/8/12, sink_sof on beat 1, done_o one cycle after beat 12, err_o=0.
REQ-026 sink_ready toggling 1/0 every cycle, src_valid random -> same 12 pixels in order, no loss/duplication, done_o once.
REQ-027 model asserts last on beat 3 instead of 4 -> err_o=1 from that beat until next start_i.
REQ-028 abort_i after 5 input beats -> FLUSH, src_ready_o=0, returns IDLE 4 cycles after pipe_valid_i last high, done_o never asserts.
REQ-029 resetn_i low during DRAIN -> busy_o=0, done_o=0 immediately; subsequent start runs a full clean frame.
